pifo_port_arbiter: RTL and testbench
====================================

# pifo_port_arbiter

- Packet-level scheduler that shares one egress AXI-Stream port among NUM_Q PIFO output queues.
- Each queue presents its head packet together with a 32-bit tpifo tag. The arbiter grants the queue whose head has the lowest rank, breaking ties round-robin, and holds that grant until the packet's tlast beat has transferred.
- It sits between the per-class output queues and the port's MAC-side interface.

## Interface
Parameters:
- NUM_Q, 4, number of requesting queues (2..8)
- DATA_W, 256, tdata width; tkeep is DATA_W/8
- USER_W, 128, tuser width
- PIFO_W, 32, tpifo width. Bit 31 is the rank-valid flag, bits 30:12 are the 19-bit rank, bits 11:0 are reserved.

Ports:
- axis_aclk  in  1  clock; all logic on the rising edge.
- axis_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_Q*DATA_W  per-queue data; queue i occupies slice i.
- s_axis_tkeep  in  NUM_Q*DATA_W/8  per-queue byte enables.
- s_axis_tuser  in  NUM_Q*USER_W  per-queue metadata.
- s_axis_tpifo  in  NUM_Q*PIFO_W  per-queue head tag. Sampled only at arbitration.
- s_axis_tvalid  in  NUM_Q  per-queue valid.
- s_axis_tlast  in  NUM_Q  per-queue end of packet.
- s_axis_tready  out  NUM_Q  per-queue ready. At most one bit is set.
- m_axis_tdata / tkeep / tuser / tpifo  out  same widths as one queue  egress beat.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tlast  out  1  egress end of packet.
- m_axis_tready  in  1  egress ready.
- grant_idx  out  $clog2(NUM_Q)  index of the queue currently granted.
- grant_active  out  1  high while a packet is being forwarded.

## Operation
- State machine with two states, ARB and XFER. Reset state is ARB.
- Effective rank of queue i:
  - tpifo[30:12] when tvalid[i]=1 and tpifo[31]=1;
  - 19'h7FFFF when tvalid[i]=1 and tpifo[31]=0;
  - not a candidate when tvalid[i]=0.
- ARB, no candidate: remain in ARB, outputs idle.
- ARB, at least one candidate:
  - Select the minimum effective rank, compared as a 19-bit unsigned value.
  - On a tie, choose the first tied queue at or after rr_ptr, searching upward modulo NUM_Q.
  - Register the winner into grant_idx, then go to XFER.
- XFER:
  - m_axis_* = s_axis_*[grant_idx], passed through combinationally.
  - s_axis_tready[grant_idx] = m_axis_tready; all other ready bits are 0.
- When a beat with tvalid & tready & tlast transfers in XFER:
  - rr_ptr <= grant_idx+1 (mod NUM_Q);
  - return to ARB.
- A granted queue that drops tvalid mid-packet stalls the port. The grant is never revoked before tlast.
- Rank ties between packets with no tag (tpifo[31]=0) are likewise resolved round-robin.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=ARB, grant_idx=0, rr_ptr=0, grant_active=0;
  - m_axis_tvalid=0, s_axis_tready=0;
  - m_axis_tdata/tkeep/tuser/tpifo/tlast drive 0 while not in XFER.
- Latency from a candidate appearing in ARB to the first egress beat is 1 cycle: decision on edge N, m_axis_tvalid at N+1.
- One mandatory ARB bubble cycle separates consecutive packets. Peak throughput is therefore L/(L+1) beats per cycle for L-beat packets.
- Single-beat packet (tlast on its first beat): XFER lasts 1 cycle if m_axis_tready=1.
- tpifo changes after the decision edge do not affect the current grant.
- A reset asserted mid-packet aborts the transfer immediately. The truncated packet is the upstream queue's concern.
- Egress follows AXI-Stream: once m_axis_tvalid is asserted, data is held stable until the handshake, because the source queue holds its own beat.

## Structure
- Shared package pifo_pkg holds:
  - PIFO_W, RANK_MSB=30, RANK_LSB=12, RANK_W=19, RANK_VLD_BIT=31, RANK_MAX;
  - a function extracting the effective rank.
- Sub-module pifo_min_select: a combinational tree that finds the minimum rank with a round-robin tie-break. Inputs are the valid vector, the packed ranks and rr_ptr; outputs are the winner index and a found flag.
- The top level contains the FSM, the grant register and the mux.

## Test plan
- Single queue: q1 sends 3 beats (1a,1b,1c) with rank 100 and m_axis_tready=1. Required: egress beats 1a,1b,1c on consecutive cycles starting 1 cycle after tvalid; grant_idx=1; return to ARB after 1c.
- Rank order: q0 has rank 50 and q2 has rank 10, both valid in the same cycle. Required: the q2 packet goes out first; q0 follows after one bubble cycle.
- Tie round-robin: q0–q3 all hold rank 100 with continuous 2-beat packets. Required: grant sequence 0,1,2,3,0; each packet is 2 beats followed by 1 bubble.
- Backpressure: m_axis_tready is low for 5 cycles mid-packet. Required: the egress beat is held stable; s_axis_tready[grant]=0; no beat is lost or duplicated.
- Untagged versus tagged: q0 has tpifo[31]=0 and q1 has rank 0x7FFFE. Required: q1 wins.
- Reset mid-packet: assert axis_resetn=0 during beat 2 of 4. Required: all outputs are 0 immediately; after release, arbitration restarts with rr_ptr=0.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared constants and helpers for the PIFO egress port arbiter.
// A tag is {rank_valid, rank[18:0], reserved[11:0]}.
package pifo_pkg;

    localparam int PIFO_W       = 32;
    localparam int RANK_MSB     = 30;
    localparam int RANK_LSB     = 12;
    localparam int RANK_W       = 19;
    localparam int RANK_VLD_BIT = 31;
    localparam logic [RANK_W-1:0] RANK_MAX = '1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Untagged heads sort after every tagged rank except an explicit maximum.
    function automatic logic [RANK_W-1:0] eff_rank(input logic [PIFO_W-1:0] tag);
        return tag[RANK_VLD_BIT] ? tag[RANK_MSB:RANK_LSB] : RANK_MAX;
    endfunction

endpackage

// File: rtl/pifo_min_select.sv
// Minimum-rank selector with a round-robin tie-break starting at rr_ptr.
// Purely combinational; found is low when no request is valid.
module pifo_min_select
    import pifo_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int IDX_W = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0]        valid,
    input  logic [NUM_Q*RANK_W-1:0] ranks,
    input  logic [IDX_W-1:0]        rr_ptr,
    output logic [IDX_W-1:0]        win_idx,
    output logic                    found
);

    logic [RANK_W-1:0] rank_a [NUM_Q];
    logic [RANK_W-1:0] min_rank;
    logic              hit;
    int                j;

    genvar g;
    for (g = 0; g < NUM_Q; g++) begin : g_unpack
        assign rank_a[g] = ranks[g*RANK_W +: RANK_W];
    end

    always_comb begin
        min_rank = RANK_MAX;
        found    = 1'b0;
        win_idx  = '0;
        hit      = 1'b0;
        j        = 0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (valid[i] && (!found || rank_a[i] < min_rank)) begin
                min_rank = rank_a[i];
                found    = 1'b1;
            end
        end
        // Walk upward from rr_ptr so the first tied queue at or after it wins.
        for (int k = 0; k < NUM_Q; k++) begin
            if (int'(rr_ptr) + k < NUM_Q) j = int'(rr_ptr) + k;
            else                          j = int'(rr_ptr) + k - NUM_Q;
            if (!hit && valid[j] && rank_a[j] == min_rank) begin
                win_idx = IDX_W'(j);
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pifo_port_arbiter.sv
// Packet-level egress arbiter: lowest-rank PIFO head wins, ties round-robin,
// grant held until the packet's tlast beat transfers.
module pifo_port_arbiter #(
    parameter int NUM_Q  = 4,
    parameter int DATA_W = 256,
    parameter int USER_W = 128,
    parameter int PIFO_W = 32
) (
    input  logic                       axis_aclk,
    input  logic                       axis_resetn,
    input  logic [NUM_Q*DATA_W-1:0]    s_axis_tdata,
    input  logic [NUM_Q*DATA_W/8-1:0]  s_axis_tkeep,
    input  logic [NUM_Q*USER_W-1:0]    s_axis_tuser,
    input  logic [NUM_Q*PIFO_W-1:0]    s_axis_tpifo,
    input  logic [NUM_Q-1:0]           s_axis_tvalid,
    input  logic [NUM_Q-1:0]           s_axis_tlast,
    output logic [NUM_Q-1:0]           s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [DATA_W/8-1:0]        m_axis_tkeep,
    output logic [USER_W-1:0]          m_axis_tuser,
    output logic [PIFO_W-1:0]          m_axis_tpifo,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [$clog2(NUM_Q)-1:0]   grant_idx,
    output logic                       grant_active
);
    import pifo_pkg::RANK_W;
    import pifo_pkg::eff_rank;
    import pifo_pkg::arb_state_t;
    import pifo_pkg::ST_ARB;
    import pifo_pkg::ST_XFER;

    // state   | meaning
    // ST_ARB  | no grant; pick the next queue when any head is valid
    // ST_XFER | forwarding queue grant_idx until its tlast beat transfers

    localparam int IDX_W  = $clog2(NUM_Q);
    localparam int KEEP_W = DATA_W/8;

    logic [DATA_W-1:0]       q_data [NUM_Q];
    logic [KEEP_W-1:0]       q_keep [NUM_Q];
    logic [USER_W-1:0]       q_user [NUM_Q];
    logic [PIFO_W-1:0]       q_pifo [NUM_Q];
    logic [NUM_Q*RANK_W-1:0] ranks;

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic              found;
    logic              xfer;
    logic              last_beat;

    genvar g;
    for (g = 0; g < NUM_Q; g++) begin : g_slice
        assign q_data[g] = s_axis_tdata[g*DATA_W +: DATA_W];
        assign q_keep[g] = s_axis_tkeep[g*KEEP_W +: KEEP_W];
        assign q_user[g] = s_axis_tuser[g*USER_W +: USER_W];
        assign q_pifo[g] = s_axis_tpifo[g*PIFO_W +: PIFO_W];
        assign ranks[g*RANK_W +: RANK_W] = eff_rank(q_pifo[g]);
    end

    pifo_min_select #(
        .NUM_Q (NUM_Q),
        .IDX_W (IDX_W)
    ) u_min_select (
        .valid   (s_axis_tvalid),
        .ranks   (ranks),
        .rr_ptr  (rr_ptr),
        .win_idx (win_idx),
        .found   (found)
    );

    assign xfer      = (state == ST_XFER);
    assign last_beat = xfer && s_axis_tvalid[grant_idx] && m_axis_tready
                       && s_axis_tlast[grant_idx];
    assign next_ptr  = (grant_idx == IDX_W'(NUM_Q-1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state        <= ST_ARB;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            grant_active <= 1'b0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (found) begin
                        grant_idx    <= win_idx;
                        state        <= ST_XFER;
                        grant_active <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (last_beat) begin
                        rr_ptr       <= next_ptr;
                        state        <= ST_ARB;
                        grant_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_ARB;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

    // Egress is a plain pass-through of the granted queue; the source holds its beat.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tpifo  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (xfer) begin
            m_axis_tdata             = q_data[grant_idx];
            m_axis_tkeep             = q_keep[grant_idx];
            m_axis_tuser             = q_user[grant_idx];
            m_axis_tpifo             = q_pifo[grant_idx];
            m_axis_tvalid            = s_axis_tvalid[grant_idx];
            m_axis_tlast             = s_axis_tlast[grant_idx];
            s_axis_tready[grant_idx] = m_axis_tready;
        end
    end

endmodule

// File: tb/tb_pifo_port_arbiter.sv
// Scoreboard bench for pifo_port_arbiter: per-queue source models feed the DUT,
// expected egress beats are queued by the stimulus and checked by a monitor.
module tb_pifo_port_arbiter;

    localparam int NQ = 4;
    localparam int DW = 32;
    localparam int UW = 16;
    localparam int PW = 32;
    localparam int KW = DW/8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [PW-1:0] pifo;
    } beat_t;

    typedef struct {
        int            q;
        logic [DW-1:0] data;
        logic          last;
        logic [PW-1:0] pifo;
        int            cyc;
    } exp_t;

    logic              clk;
    logic              axis_resetn;
    logic [NQ*DW-1:0]  s_tdata;
    logic [NQ*KW-1:0]  s_tkeep;
    logic [NQ*UW-1:0]  s_tuser;
    logic [NQ*PW-1:0]  s_tpifo;
    logic [NQ-1:0]     s_tvalid;
    logic [NQ-1:0]     s_tlast;
    logic [NQ-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic [PW-1:0]     m_tpifo;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [1:0]        grant_idx;
    logic              grant_active;

    beat_t src [NQ][$];
    exp_t  exp_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    logic [NQ-1:0] hs;

    pifo_port_arbiter #(
        .NUM_Q (NQ), .DATA_W (DW), .USER_W (UW), .PIFO_W (PW)
    ) dut (
        .axis_aclk     (clk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tpifo  (s_tpifo),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tpifo  (m_tpifo),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_idx     (grant_idx),
        .grant_active  (grant_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [PW-1:0] tag(input int r);
        return {1'b1, 19'(r), 12'h000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < NQ; i++) begin
            s_tkeep[i*KW +: KW] = '1;
            s_tuser[i*UW +: UW] = UW'(i);
            if (src[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = src[i][0].data;
                s_tlast[i]           = src[i][0].last;
                s_tpifo[i*PW +: PW]  = src[i][0].pifo;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
                s_tlast[i]           = 1'b0;
                s_tpifo[i*PW +: PW]  = '0;
            end
        end
    endtask

    task automatic src_pkt(input int q, input int n, input logic [PW-1:0] p, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = (i == n-1);
            b.pifo = p;
            src[q].push_back(b);
        end
    endtask

    task automatic exp_beat(input int q, input logic [DW-1:0] d, input logic l, input logic [PW-1:0] p, input int c);
        exp_t e;
        e.q = q; e.data = d; e.last = l; e.pifo = p; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int q, input int n, input logic [PW-1:0] p, input logic [DW-1:0] base, input int c0);
        for (int i = 0; i < n; i++)
            exp_beat(q, base + DW'(i), (i == n-1), p, c0 + i);
    endtask

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0);
        for (int i = 0; i < NQ; i++)
            if (src[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input string nm, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(posedge clk);
            #2;
            if (all_empty()) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_%s: %0d beats still expected, required 0", nm, exp_q.size());
            exp_q.delete();
            for (int i = 0; i < NQ; i++) src[i].delete();
            apply_src();
        end
    endtask

    // Source model: handshake is sampled mid-cycle, the beat retired after the edge.
    initial forever begin
        @(negedge clk);
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++)
            if (hs[i] && src[i].size() > 0) void'(src[i].pop_front());
        apply_src();
    end

    initial forever begin
        @(negedge clk);
        if (axis_resetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h from q%0d, required none", m_tdata, grant_idx);
            end else begin
                exp_t e;
                logic [NQ-1:0] oh;
                e  = exp_q.pop_front();
                oh = NQ'(1) << e.q;
                chk("beat_data", 64'(m_tdata), 64'(e.data));
                chk("beat_last", 64'(m_tlast), 64'(e.last));
                chk("beat_pifo", 64'(m_tpifo), 64'(e.pifo));
                chk("beat_tuser", 64'(m_tuser), 64'(e.q));
                chk("beat_tkeep", 64'(m_tkeep), 64'(4'hF));
                chk("beat_grant_idx", 64'(grant_idx), 64'(e.q));
                chk("beat_tready_onehot", 64'(s_tready), 64'(oh));
                chk("beat_grant_active", 64'(grant_active), 64'd1);
                if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        axis_resetn = 1'b0;
        m_tready    = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tpifo = '0;
        s_tvalid = '0; s_tlast = '0;
        apply_src();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_grant_active", 64'(grant_active), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        axis_resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Tie round-robin: grants 0,1,2,3,0, each 2 beats then one bubble.
        @(posedge clk); #1;
        c = cyc;
        src_pkt(0, 2, tag(100), 32'h00);
        src_pkt(0, 2, tag(100), 32'h08);
        src_pkt(1, 2, tag(100), 32'h10);
        src_pkt(2, 2, tag(100), 32'h20);
        src_pkt(3, 2, tag(100), 32'h30);
        exp_pkt(0, 2, tag(100), 32'h00, c + 1);
        exp_pkt(1, 2, tag(100), 32'h10, c + 4);
        exp_pkt(2, 2, tag(100), 32'h20, c + 7);
        exp_pkt(3, 2, tag(100), 32'h30, c + 10);
        exp_pkt(0, 2, tag(100), 32'h08, c + 13);
        apply_src();
        wait_drain("tie_rr", 40);

        // Single queue, three beats back to back, then back to ARB.
        @(posedge clk); #1;
        c = cyc;
        src_pkt(1, 3, tag(100), 32'h1a);
        exp_pkt(1, 3, tag(100), 32'h1a, c + 1);
        apply_src();
        wait_drain("single", 20);
        chk("single_back_to_arb", 64'(grant_active), 64'd0);

        // Rank order: q2 (rank 10) before q0 (rank 50).
        @(posedge clk); #1;
        c = cyc;
        src_pkt(0, 2, tag(50), 32'hA0);
        src_pkt(2, 2, tag(10), 32'hB0);
        exp_pkt(2, 2, tag(10), 32'hB0, c + 1);
        exp_pkt(0, 2, tag(50), 32'hA0, c + 4);
        apply_src();
        wait_drain("rank_order", 20);

        // Untagged head (rank bits set but flag clear) loses to rank 0x7FFFE.
        @(posedge clk); #1;
        c = cyc;
        src_pkt(0, 1, 32'h7FFF_F000, 32'hC0);
        src_pkt(1, 1, tag('h7FFFE), 32'hD0);
        exp_pkt(1, 1, tag('h7FFFE), 32'hD0, c + 1);
        exp_pkt(0, 1, 32'h7FFF_F000, 32'hC0, c + 3);
        apply_src();
        wait_drain("untagged", 20);

        // Backpressure: 5-cycle stall on beat 2 of 4.
        @(posedge clk); #1;
        c = cyc;
        src_pkt(2, 4, tag(7), 32'h40);
        exp_beat(2, 32'h40, 1'b0, tag(7), c + 1);
        exp_beat(2, 32'h41, 1'b0, tag(7), c + 7);
        exp_beat(2, 32'h42, 1'b0, tag(7), c + 8);
        exp_beat(2, 32'h43, 1'b1, tag(7), c + 9);
        apply_src();
        @(posedge clk);
        @(posedge clk); #1;
        m_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_data_held", 64'(m_tdata), 64'h41);
            chk("stall_tvalid", 64'(m_tvalid), 64'd1);
            chk("stall_s_tready", 64'(s_tready), 64'd0);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_drain("backpressure", 20);

        // Reset during beat 2 of 4; afterwards rr_ptr must be back at 0.
        @(posedge clk); #1;
        c = cyc;
        src_pkt(2, 4, tag(9), 32'h50);
        exp_beat(2, 32'h50, 1'b0, tag(9), c + 1);
        apply_src();
        @(posedge clk);
        @(posedge clk); #2;
        chk("pre_reset_beat2", 64'(m_tdata), 64'h51);
        axis_resetn = 1'b0;
        for (int i = 0; i < NQ; i++) src[i].delete();
        apply_src();
        #1;
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_m_tdata", 64'(m_tdata), 64'd0);
        chk("midrst_m_tlast", 64'(m_tlast), 64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        chk("midrst_grant_active", 64'(grant_active), 64'd0);
        chk("midrst_grant_idx", 64'(grant_idx), 64'd0);
        chk("midrst_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        axis_resetn = 1'b1;
        @(posedge clk); #1;
        c = cyc;
        src_pkt(3, 1, tag(5), 32'h70);
        src_pkt(0, 1, tag(5), 32'h60);
        exp_pkt(0, 1, tag(5), 32'h60, c + 1);
        exp_pkt(3, 1, tag(5), 32'h70, c + 3);
        apply_src();
        wait_drain("post_reset_rr", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
